// File: rtl/multdiv_stall_ctrl_if.sv
// Bundle of pipeline-side and multdiv-unit-side signals around the multdiv stall controller.
// The master modport is the controller; the slave modport is the pipeline and unit.
interface multdiv_stall_ctrl_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      insn_dx;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [WIDTH-1:0] md_result;
   logic             md_exception;
   logic             md_ready;
   logic             ctrl_mult;
   logic             ctrl_div;
   logic [WIDTH-1:0] md_operand_a;
   logic [WIDTH-1:0] md_operand_b;
   logic             stall;
   logic             busy;
   logic             wb_valid;
   logic [4:0]       wb_reg;
   logic [WIDTH-1:0] wb_data;
   logic             timeout_err;

   modport master (
      input  insn_dx, operand_a, operand_b, md_result, md_exception, md_ready,
      output ctrl_mult, ctrl_div, md_operand_a, md_operand_b, stall, busy,
             wb_valid, wb_reg, wb_data, timeout_err
   );

   modport slave (
      output insn_dx, operand_a, operand_b, md_result, md_exception, md_ready,
      input  ctrl_mult, ctrl_div, md_operand_a, md_operand_b, stall, busy,
             wb_valid, wb_reg, wb_data, timeout_err
   );
endinterface

// File: rtl/multdiv_stall_ctrl.sv
// Launches the multi-cycle mul/div unit from DX, stalls the front of the pipe while it runs,
// and substitutes its result (or the rstatus exception code) for the ALU output into XM.
//
// state | meaning
// IDLE  | no op in flight; a mul/div in DX stalls and latches its operands
// START | one-cycle ctrl_mult/ctrl_div pulse to the unit
// WAIT  | waiting for md_ready, bounded by TIMEOUT cycles
// DONE  | pipe released for one cycle; result or exception goes to XM
module multdiv_stall_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 40
) (
   input  logic                 clock,
   input  logic                 reset,
   multdiv_stall_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic             op_div;
   logic [4:0]       rd_q;
   logic [WIDTH-1:0] opa_q, opb_q, res_q;
   logic             exc_q;
   logic             tout_q;

   logic             is_rtype, detect, timed_out;
   logic [4:0]       alu_op;

   logic             ctrl_mult, ctrl_div, stall, busy, wb_valid;
   logic [4:0]       wb_reg;
   logic [WIDTH-1:0] wb_data;

   assign is_rtype  = (bus.insn_dx[31:27] == 5'b00000);
   assign alu_op    = bus.insn_dx[6:2];
   // Gated by reset so stall drops the moment reset asserts, even with a mul/div sitting in DX.
   assign detect    = reset && is_rtype && (alu_op == 5'b00110 || alu_op == 5'b00111);
   assign timed_out = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ctrl_mult = 1'b0;
      ctrl_div  = 1'b0;
      stall     = 1'b0;
      wb_valid  = 1'b0;
      wb_reg    = 5'd0;
      wb_data   = '0;
      case (state)
         IDLE: begin
            if (detect) begin
               stall     = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            ctrl_mult = ~op_div;
            ctrl_div  = op_div;
            stall     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (bus.md_ready || timed_out) state_nxt = DONE;
         end
         DONE: begin
            // A clean result for $0 still releases the pipe but writes nothing.
            wb_valid  = exc_q | (rd_q != 5'd0);
            wb_reg    = exc_q ? 5'd30 : rd_q;
            wb_data   = exc_q ? (op_div ? WIDTH'(5) : WIDTH'(4)) : res_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         op_div <= 1'b0;
         rd_q   <= 5'd0;
         opa_q  <= '0;
         opb_q  <= '0;
         res_q  <= '0;
         exc_q  <= 1'b0;
         tout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (detect) begin
                  op_div <= alu_op[0];
                  rd_q   <= bus.insn_dx[26:22];
                  opa_q  <= bus.operand_a;
                  opb_q  <= bus.operand_b;
                  res_q  <= '0;
                  exc_q  <= 1'b0;
               end
            end
            START: cnt <= '0;
            WAIT: begin
               cnt <= cnt + CW'(1);
               if (bus.md_ready) begin
                  res_q <= bus.md_result;
                  exc_q <= bus.md_exception;
               end else if (timed_out) begin
                  exc_q  <= 1'b1;
                  tout_q <= 1'b1;
               end
            end
            DONE: cnt <= '0;
            default: cnt <= '0;
         endcase
      end
   end

   assign busy = (state != IDLE);

   assign bus.ctrl_mult    = ctrl_mult;
   assign bus.ctrl_div     = ctrl_div;
   assign bus.md_operand_a = busy ? opa_q : '0;
   assign bus.md_operand_b = busy ? opb_q : '0;
   assign bus.stall        = stall;
   assign bus.busy         = busy;
   assign bus.wb_valid     = wb_valid;
   assign bus.wb_reg       = wb_reg;
   assign bus.wb_data      = wb_data;
   assign bus.timeout_err  = tout_q;
endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for the multdiv stall controller: mul, div exception, timeout,
// back-to-back ops, async reset mid-operation and a non-multdiv instruction stream.
module tb_multdiv_stall_ctrl;
   localparam int TIMEOUT = 40;
   localparam logic [4:0] MUL = 5'b00110;
   localparam logic [4:0] DIV = 5'b00111;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   multdiv_stall_ctrl_if #(.WIDTH(32)) bus ();

   multdiv_stall_ctrl #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] alu);
      return {5'b00000, rd, 5'd1, 5'd2, 5'd0, alu, 2'b00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drives one mul/div from its detect cycle through DONE and into the following IDLE cycle,
   // where nxt is already in DX. ready_at = 0 means the unit never answers.
   task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                        input int ready_at, input logic [31:0] res, input logic exc,
                        input logic is_div, input logic exp_valid, input logic [4:0] exp_reg,
                        input logic [31:0] exp_data, input logic [31:0] nxt);
      int n;
      bus.insn_dx   = insn;
      bus.operand_a = a;
      bus.operand_b = b;
      #2;
      chk("detect_stall", bus.stall, 1);
      chk("detect_busy", bus.busy, 0);
      chk("detect_pulse", bus.ctrl_mult | bus.ctrl_div, 0);
      step();
      bus.operand_a    = 32'hdead_0000;
      bus.operand_b    = 32'hbeef_0000;
      bus.md_ready     = 1'b1;
      bus.md_exception = 1'b0;
      bus.md_result    = 32'h0000_0999;
      #2;
      chk("start_mult", bus.ctrl_mult, !is_div);
      chk("start_div", bus.ctrl_div, is_div);
      chk("start_stall", bus.stall, 1);
      chk("start_busy", bus.busy, 1);
      chk("start_opa", bus.md_operand_a, a);
      chk("start_opb", bus.md_operand_b, b);
      n = (ready_at == 0) ? TIMEOUT : ready_at;
      for (int i = 1; i <= n; i++) begin
         step();
         bus.md_ready     = (ready_at != 0) && (i == ready_at);
         bus.md_result    = res;
         bus.md_exception = exc && bus.md_ready;
         #2;
         chk("wait_stall", bus.stall, 1);
         chk("wait_pulse", bus.ctrl_mult | bus.ctrl_div, 0);
         chk("wait_wb", bus.wb_valid, 0);
         chk("wait_opb", bus.md_operand_b, b);
      end
      step();
      bus.md_ready     = 1'b0;
      bus.md_exception = 1'b0;
      bus.insn_dx      = nxt;
      #2;
      chk("done_valid", bus.wb_valid, exp_valid);
      chk("done_reg", bus.wb_reg, exp_reg);
      chk("done_data", bus.wb_data, exp_data);
      chk("done_stall", bus.stall, 0);
      chk("done_busy", bus.busy, 1);
      step();
      #2;
      chk("idle_busy", bus.busy, 0);
      chk("idle_wb", bus.wb_valid, 0);
      chk("idle_reg", bus.wb_reg, 0);
      chk("idle_data", bus.wb_data, 0);
   endtask

   initial begin
      reset            = 1'b0;
      bus.insn_dx      = 32'd0;
      bus.operand_a    = 32'd0;
      bus.operand_b    = 32'd0;
      bus.md_result    = 32'd0;
      bus.md_exception = 1'b0;
      bus.md_ready     = 1'b0;
      #2;
      chk("rst_stall", bus.stall, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wb", bus.wb_valid, 0);
      chk("rst_tout", bus.timeout_err, 0);
      @(negedge clock);
      reset = 1'b1;
      step();

      // mul $3 = 6*7, unit answers on the 17th WAIT cycle
      do_op(rtype(5'd3, MUL), 6, 7, 17, 42, 1'b0, 1'b0, 1'b1, 5'd3, 42, 32'd0);
      chk("idle_stall_after_mul", bus.stall, 0);

      // div $4 by zero, unit flags the exception
      do_op(rtype(5'd4, DIV), 9, 0, 2, 32'h1234, 1'b1, 1'b1, 1'b1, 5'd30, 5, 32'd0);
      chk("div_exc_tout", bus.timeout_err, 0);

      // mul that never answers: exactly TIMEOUT WAIT cycles then a forced exception
      do_op(rtype(5'd9, MUL), 2, 3, 0, 0, 1'b0, 1'b0, 1'b1, 5'd30, 4, 32'd0);
      chk("tout_set", bus.timeout_err, 1);

      // mul $5 back-to-back with div $6
      do_op(rtype(5'd5, MUL), 3, 4, 3, 12, 1'b0, 1'b0, 1'b1, 5'd5, 12, rtype(5'd6, DIV));
      chk("b2b_gap_stall", bus.stall, 1);
      chk("tout_sticky", bus.timeout_err, 1);
      do_op(rtype(5'd6, DIV), 20, 4, 5, 5, 1'b0, 1'b1, 1'b1, 5'd6, 5, 32'd0);

      // async reset in the middle of WAIT, with the mul still in DX
      bus.insn_dx   = rtype(5'd7, MUL);
      bus.operand_a = 1;
      bus.operand_b = 1;
      step();
      step();
      step();
      #3;
      reset = 1'b0;
      #1;
      chk("arst_stall", bus.stall, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_pulse", bus.ctrl_mult | bus.ctrl_div, 0);
      chk("arst_wb", bus.wb_valid, 0);
      chk("arst_opa", bus.md_operand_a, 0);
      chk("arst_tout", bus.timeout_err, 0);
      bus.insn_dx = 32'd0;
      @(negedge clock);
      reset = 1'b1;
      step();
      do_op(rtype(5'd8, MUL), 3, 3, 1, 9, 1'b0, 1'b0, 1'b1, 5'd8, 9, 32'd0);

      // non-multdiv stream with a stray md_ready, then mul $0
      bus.md_ready = 1'b1;
      bus.insn_dx  = rtype(5'd3, 5'b00000);
      #2;
      chk("add_stall", bus.stall, 0);
      step();
      bus.insn_dx = {5'b00101, 5'd3, 5'd1, 17'h00018};
      #2;
      chk("addi_stall", bus.stall, 0);
      step();
      bus.insn_dx = {5'b00111, 5'd2, 5'd1, 17'h0001C};
      #2;
      chk("sw_stall", bus.stall, 0);
      chk("sw_busy", bus.busy, 0);
      chk("sw_wb", bus.wb_valid, 0);
      step();
      bus.md_ready = 1'b0;
      do_op(rtype(5'd0, MUL), 3, 3, 1, 9, 1'b0, 1'b0, 1'b0, 5'd0, 9, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
